// File: rtl/led_racer_pkg.sv
// Shared types and 50 MHz default timing for the LED-strip frame path.
// Optional build macro WS2812_DIM_EN selects the dimmed-channel helper at word capture.
package led_racer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int DEF_MAX_POS  = 16;
    localparam int DEF_T0H_CYC  = 20;
    localparam int DEF_T1H_CYC  = 40;
    localparam int DEF_TBIT_CYC = 63;
    localparam int DEF_TRES_CYC = 2500;

    typedef logic [23:0] grb_word_t;

    function automatic logic [7:0] dim_channel(input logic [7:0] value);
        return value >> 2;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// One WS2812 bit cell: high for T0H/T1H cycles, low for the rest of TBIT_CYC.
// A start in the cell_done cycle chains the next cell with no gap.
module ws2812_bit_encoder #(
    parameter int T0H_CYC  = 20,
    parameter int T1H_CYC  = 40,
    parameter int TBIT_CYC = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    input  logic i_bit,
    output logic o_data,
    output logic o_cell_done
);

    localparam int CW = (TBIT_CYC > 2) ? $clog2(TBIT_CYC) : 1;
    localparam logic [CW-1:0] C_T0H  = CW'(T0H_CYC);
    localparam logic [CW-1:0] C_T1H  = CW'(T1H_CYC);
    localparam logic [CW-1:0] C_LAST = CW'(TBIT_CYC - 1);

    logic [CW-1:0] r_cnt;
    logic          r_bit;
    logic          r_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_bit    <= 1'b0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= '0;
            r_bit    <= i_bit;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == C_LAST) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output is decoded from registers only, so reset forces the line low immediately.
    assign o_data      = r_active && (r_cnt < (r_bit ? C_T1H : C_T0H));
    assign o_cell_done = r_active && (r_cnt == C_LAST);

endmodule

// File: rtl/ws2812_frame_sender.sv
// Frame walker: fetches GRB per LED, streams 24-bit words back-to-back, then latches.
// Build macro WS2812_DIM_EN: each channel is captured as value>>2.
module ws2812_frame_sender
    import led_racer_pkg::*;
#(
    parameter int MAX_POS  = DEF_MAX_POS,
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC,
    parameter int TBIT_CYC = DEF_TBIT_CYC,
    parameter int TRES_CYC = DEF_TRES_CYC,
    localparam int LED_W   = (MAX_POS > 1) ? $clog2(MAX_POS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             update_frame,
    input  logic [7:0]       led_green_intensity,
    input  logic [7:0]       led_red_intensity,
    input  logic [7:0]       led_blue_intensity,
    output logic [LED_W-1:0] current_led,
    output logic             busy,
    output logic             data_out
);

    localparam int CNT_W = $clog2(((TBIT_CYC > TRES_CYC) ? TBIT_CYC : TRES_CYC) + 1);
    localparam logic [LED_W-1:0] C_LED_LAST  = LED_W'(MAX_POS - 1);
    localparam logic [CNT_W-1:0] C_TRES_LAST = CNT_W'(TRES_CYC - 1);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [LED_W-1:0] r_led, w_led_next;
    logic [4:0]       r_bit_idx, w_bit_idx_next;
    grb_word_t        r_shift, w_shift_next, w_capture;
    logic             r_pending, w_pending_next;
    logic             r_last_word, w_last_word_next;
    logic             w_start, w_start_bit, w_cell_done, w_enc_data;

`ifdef WS2812_DIM_EN
    assign w_capture = {dim_channel(led_green_intensity),
                        dim_channel(led_red_intensity),
                        dim_channel(led_blue_intensity)};
`else
    assign w_capture = {led_green_intensity, led_red_intensity, led_blue_intensity};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LATCH;
            r_cnt       <= '0;
            r_led       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_pending   <= 1'b0;
            r_last_word <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_led       <= w_led_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_pending   <= w_pending_next;
            r_last_word <= w_last_word_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_led_next       = r_led;
        w_bit_idx_next   = r_bit_idx;
        w_shift_next     = r_shift;
        w_last_word_next = r_last_word;
        w_pending_next   = r_pending | (update_frame && (r_state != IDLE));
        w_start          = 1'b0;
        w_start_bit      = 1'b0;
        case (r_state)
            IDLE: begin
                if (update_frame || r_pending) begin
                    w_state_next   = LOAD;
                    w_led_next     = '0;
                    w_pending_next = 1'b0;
                end
            end
            LOAD: begin
                w_shift_next     = w_capture;
                w_bit_idx_next   = 5'd23;
                w_last_word_next = (r_led == C_LED_LAST);
                w_start          = 1'b1;
                w_start_bit      = w_capture[23];
                w_state_next     = SEND;
            end
            SEND: begin
                if (w_cell_done) begin
                    if (r_bit_idx != 5'd0) begin
                        w_shift_next   = {r_shift[22:0], 1'b0};
                        w_bit_idx_next = r_bit_idx - 5'd1;
                        w_start        = 1'b1;
                        w_start_bit    = r_shift[22];
                        // Advance the index a full cell early so upstream lookup settles.
                        if (r_bit_idx == 5'd1 && !r_last_word) begin
                            w_led_next = r_led + 1'b1;
                        end
                    end else if (!r_last_word) begin
                        w_shift_next     = w_capture;
                        w_bit_idx_next   = 5'd23;
                        w_last_word_next = (r_led == C_LED_LAST);
                        w_start          = 1'b1;
                        w_start_bit      = w_capture[23];
                    end else begin
                        w_state_next = LATCH;
                        w_cnt_next   = '0;
                        w_led_next   = '0;
                    end
                end
            end
            LATCH: begin
                if (r_cnt == C_TRES_LAST) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = LATCH;
        endcase
    end

    ws2812_bit_encoder #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_bit_encoder (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_bit       (w_start_bit),
        .o_data      (w_enc_data),
        .o_cell_done (w_cell_done)
    );

    assign current_led = r_led;
    assign busy        = (r_state != IDLE);
    assign data_out    = w_enc_data;

endmodule

// File: tb/tb_ws2812_frame_sender.sv
// Directed bench for ws2812_frame_sender with a 2-LED strip and short bit timing.
// Expected bit tables switch with WS2812_DIM_EN.
module tb_ws2812_frame_sender;

    localparam int MAX_POS = 2;
    localparam int T0H     = 2;
    localparam int T1H     = 4;
    localparam int TBIT    = 6;
    localparam int TRES    = 10;
    localparam int NCAP    = 302;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        update_frame = 1'b0;
    logic [7:0]  g_in, r_in, b_in;
    logic [0:0]  current_led;
    logic        busy, data_out;
    logic [23:0] w0_tb = '0;
    logic [23:0] w1_tb = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Upstream lookup: combinational on current_led.
    always_comb begin
        if (current_led == 1'b0) {g_in, r_in, b_in} = w0_tb;
        else                     {g_in, r_in, b_in} = w1_tb;
    end

    ws2812_frame_sender #(
        .MAX_POS  (MAX_POS),
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .TBIT_CYC (TBIT),
        .TRES_CYC (TRES)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .update_frame        (update_frame),
        .led_green_intensity (g_in),
        .led_red_intensity   (r_in),
        .led_blue_intensity  (b_in),
        .current_led         (current_led),
        .busy                (busy),
        .data_out            (data_out)
    );

    typedef struct {
        logic [23:0] w0;
        logic [23:0] w1;
        logic [47:0] exp_bits;
        int          pa, pb, pc;
        bit          exp_extra;
    } vec_t;

    vec_t vecs[3];
    logic cap_data[NCAP];
    logic cap_busy[NCAP];
    int   cap_led[NCAP];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end else begin
            $display("ok   %s got=%0d", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // k=0 is the LOAD cycle right after the request edge.
    task automatic capture(input int pa, input int pb, input int pc);
        for (int k = 0; k < NCAP; k++) begin
            cap_data[k] = data_out;
            cap_busy[k] = busy;
            cap_led[k]  = int'(current_led);
            update_frame = (k == pa) || (k == pb) || (k == pc);
            tick();
        end
        update_frame = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        check("idle_reached", int'(busy), 0);
    endtask

    task automatic check_frame(input int vi);
        int bad;
        logic [5:0] act, exp;
        bad = 0;
        for (int k = 0; k < 299; k++) if (cap_busy[k] !== 1'b1) bad++;
        if (cap_busy[299] !== 1'b0) bad++;
        check($sformatf("v%0d busy_window_bad", vi), bad, 0);
        check($sformatf("v%0d busy_k300", vi), int'(cap_busy[300]), int'(vecs[vi].exp_extra));
        check($sformatf("v%0d busy_k301", vi), int'(cap_busy[301]), int'(vecs[vi].exp_extra));
        for (int j = 0; j < 48; j++) begin
            for (int p = 0; p < 6; p++) act[5-p] = cap_data[1 + 6*j + p];
            exp = vecs[vi].exp_bits[47-j] ? 6'b111100 : 6'b110000;
            check($sformatf("v%0d cell%0d", vi, j), int'(act), int'(exp));
        end
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            if (cap_led[k] != (((k >= 139) && (k <= 288)) ? 1 : 0)) bad++;
        end
        check($sformatf("v%0d led_seq_bad", vi), bad, 0);
        bad = 0;
        if (cap_data[0] !== 1'b0) bad++;
        for (int k = 289; k < 300; k++) if (cap_data[k] !== 1'b0) bad++;
        check($sformatf("v%0d latch_low_bad", vi), bad, 0);
    endtask

    initial begin
        int n, bad;
        vecs[0] = '{w0: 24'hA5_00_FF, w1: 24'h01_01_01,
`ifdef WS2812_DIM_EN
                    exp_bits: 48'h29_00_3F_00_00_00,
`else
                    exp_bits: 48'hA5_00_FF_01_01_01,
`endif
                    pa: -1, pb: -1, pc: -1, exp_extra: 1'b0};
        vecs[1] = '{w0: 24'hFF_3C_80, w1: 24'h7E_C3_00,
`ifdef WS2812_DIM_EN
                    exp_bits: 48'h3F_0F_20_1F_30_00,
`else
                    exp_bits: 48'hFF_3C_80_7E_C3_00,
`endif
                    pa: 50, pb: 100, pc: 200, exp_extra: 1'b1};
        vecs[2] = '{w0: 24'h00_00_00, w1: 24'hFF_FF_FF,
`ifdef WS2812_DIM_EN
                    exp_bits: 48'h00_00_00_3F_3F_3F,
`else
                    exp_bits: 48'h00_00_00_FF_FF_FF,
`endif
                    pa: 298, pb: -1, pc: -1, exp_extra: 1'b1};

        // Reset state and post-reset latch.
        tick();
        tick();
        check("rst data_out", int'(data_out), 0);
        check("rst current_led", int'(current_led), 0);
        check("rst busy", int'(busy), 1);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b1 || data_out !== 1'b0) bad++;
            tick();
        end
        check("post_reset_latch_bad", bad, 0);
        check("post_reset_idle busy", int'(busy), 0);
        tick();

        // Table-driven frames.
        for (int vi = 0; vi < 3; vi++) begin
            w0_tb = vecs[vi].w0;
            w1_tb = vecs[vi].w1;
            update_frame = 1'b1;
            tick();
            capture(vecs[vi].pa, vecs[vi].pb, vecs[vi].pc);
            check_frame(vi);
            wait_idle(n);
            if (vecs[vi].exp_extra) check($sformatf("v%0d extra_frame_len", vi), n, 297);
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                if (busy !== 1'b0) bad++;
                tick();
            end
            check($sformatf("v%0d stays_idle_bad", vi), bad, 0);
        end

        // Reset mid-cell while the line is high, with a request during the reset latch.
        w0_tb = 24'hA5_00_FF;
        w1_tb = 24'h01_01_01;
        update_frame = 1'b1;
        tick();
        update_frame = 1'b0;
        for (int i = 0; i < 140; i++) tick();
        check("pre_rst data_out", int'(data_out), 1);
        check("pre_rst current_led", int'(current_led), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst data_out", int'(data_out), 0);
        check("mid_rst current_led", int'(current_led), 0);
        tick();
        tick();
        rst_n = 1'b1;
        update_frame = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b1 || data_out !== 1'b0) bad++;
            tick();
            update_frame = 1'b0;
        end
        check("rst2_latch_bad", bad, 0);
        check("rst2_idle_gap busy", int'(busy), 0);
        tick();
        check("rst2_load busy", int'(busy), 1);
        tick();
        check("rst2_first_cell data_out", int'(data_out), 1);
        wait_idle(n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
